// File: rtl/boot_word_loader.sv
// boot_word_loader: serial bootloader front end that assembles 32-bit words MSB-first for the instruction ROM
//   clk          system clock
//   reset        asynchronous active-high reset
//   enable       loader armed; low flushes the partial word and restarts addressing at 0
//   data_pin     serial data from the host, asynchronous to clk
//   data_clk_pin host strobe, asynchronous to clk; data valid on its rising edge
//   out          last completed word
//   addr         address of out
//   ready        one-cycle strobe: out/addr hold a new word
//   word_count   saturating count of words committed since reset or enable low
//   overflow     sticky: address wrapped past its top value
//   frame_err    sticky: a partial word timed out
module boot_word_loader #(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              data_pin,
  input  logic              data_clk_pin,
  output logic [31:0]       out,
  output logic [ADDR_W-1:0] addr,
  output logic              ready,
  output logic [ADDR_W:0]   word_count,
  output logic              overflow,
  output logic              frame_err
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic {IDLE, RECV} state_t;
  state_t            state_q, state_d;
  logic [1:0]        data_sync_q, strb_sync_q;
  logic              strb_prev_q;
  logic [4:0]        bit_cnt_q, bit_cnt_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [31:0]       sr_q, sr_d;
  logic [31:0]       out_q, out_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              first_q, first_d;
  logic              ready_q, ready_d;
  logic [ADDR_W:0]   wc_q, wc_d;
  logic              ovf_q, ovf_d;
  logic              ferr_q, ferr_d;
  logic              strobe_edge, bit_in;
  // Synchronisers and edge detector run regardless of enable, so a strobe
  // already high when enable rises is not mistaken for a fresh edge.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      data_sync_q <= '0;
      strb_sync_q <= '0;
      strb_prev_q <= 1'b0;
    end else begin
      data_sync_q <= {data_sync_q[0], data_pin};
      strb_sync_q <= {strb_sync_q[0], data_clk_pin};
      strb_prev_q <= strb_sync_q[1];
    end
  assign strobe_edge = strb_sync_q[1] & ~strb_prev_q;
  assign bit_in      = data_sync_q[1];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      timer_q   <= '0;
      sr_q      <= '0;
      out_q     <= '0;
      addr_q    <= '0;
      first_q   <= 1'b1;
      ready_q   <= 1'b0;
      wc_q      <= '0;
      ovf_q     <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      timer_q   <= timer_d;
      sr_q      <= sr_d;
      out_q     <= out_d;
      addr_q    <= addr_d;
      first_q   <= first_d;
      ready_q   <= ready_d;
      wc_q      <= wc_d;
      ovf_q     <= ovf_d;
      ferr_q    <= ferr_d;
    end
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    timer_d   = timer_q;
    sr_d      = sr_q;
    out_d     = out_q;
    addr_d    = addr_q;
    first_d   = first_q;
    ready_d   = 1'b0;
    wc_d      = wc_q;
    ovf_d     = ovf_q;
    ferr_d    = ferr_q;
    if (!enable) begin
      // first_q marks addr as "before 0": the next commit lands at 0.
      state_d   = IDLE;
      bit_cnt_d = '0;
      timer_d   = '0;
      addr_d    = '0;
      first_d   = 1'b1;
      wc_d      = '0;
      ovf_d     = 1'b0;
      ferr_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          timer_d   = '0;
          bit_cnt_d = '0;
          if (strobe_edge) begin
            sr_d      = {sr_q[30:0], bit_in};
            bit_cnt_d = 5'd1;
            state_d   = RECV;
          end
        end
        RECV: begin
          // An edge in the timeout cycle wins over the timeout.
          if (strobe_edge) begin
            sr_d    = {sr_q[30:0], bit_in};
            timer_d = '0;
            if (bit_cnt_q == 5'd31) begin
              out_d     = {sr_q[30:0], bit_in};
              ready_d   = 1'b1;
              addr_d    = first_q ? '0 : addr_q + 1'b1;
              first_d   = 1'b0;
              ovf_d     = ovf_q | (~first_q & (&addr_q));
              wc_d      = (&wc_q) ? wc_q : wc_q + 1'b1;
              bit_cnt_d = '0;
              state_d   = IDLE;
            end else begin
              bit_cnt_d = bit_cnt_q + 5'd1;
            end
          end else if (timer_q == TW'(TIMEOUT_CYCLES)) begin
            bit_cnt_d = '0;
            timer_d   = '0;
            ferr_d    = 1'b1;
            state_d   = IDLE;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
  assign out        = out_q;
  assign addr       = addr_q;
  assign ready      = ready_q;
  assign word_count = wc_q;
  assign overflow   = ovf_q;
  assign frame_err  = ferr_q;
endmodule

// File: tb/tb_boot_word_loader.sv
// tb_boot_word_loader: randomized scoreboard bench for boot_word_loader
module tb_boot_word_loader;
  localparam int TO = 50;
  localparam int AW = 2;
  localparam int WC_MAX = 2 ** (AW + 1) - 1;
  typedef struct {
    logic [31:0] w;
    logic [AW-1:0] a;
    logic [AW:0] wc;
    logic ov;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  logic data_pin = 1'b0;
  logic data_clk_pin = 1'b0;
  logic [31:0] out;
  logic [AW-1:0] addr;
  logic ready;
  logic [AW:0] word_count;
  logic overflow, frame_err;
  int vectors = 0;
  int miscompares = 0;
  int n_words = 0;
  exp_t sb[$];
  always #5 clk = ~clk;
  boot_word_loader #(.TIMEOUT_CYCLES(TO), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .data_pin(data_pin),
    .data_clk_pin(data_clk_pin), .out(out), .addr(addr), .ready(ready),
    .word_count(word_count), .overflow(overflow), .frame_err(frame_err)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && ready) begin
      if (sb.size() == 0) chk("unexpected_ready", 64'(ready), 64'(0));
      else begin
        e = sb.pop_front();
        chk("out", 64'(out), 64'(e.w));
        chk("addr", 64'(addr), 64'(e.a));
        chk("word_count@ready", 64'(word_count), 64'(e.wc));
        chk("overflow@ready", 64'(overflow), 64'(e.ov));
      end
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send_bits(input logic [31:0] w, input int nb, input int ph);
    for (int i = 31; i > 31 - nb; i--) begin
      data_pin = w[i];
      data_clk_pin = 1'b0;
      cyc(ph != 0 ? ph : int'($urandom_range(2, 6)));
      data_clk_pin = 1'b1;
      cyc(ph != 0 ? ph : int'($urandom_range(2, 6)));
    end
  endtask
  function automatic logic [AW:0] exp_wc(input int n);
    return (AW + 1)'(n > WC_MAX ? WC_MAX : n);
  endfunction
  task automatic send_word(input logic [31:0] w, input int ph);
    exp_t e;
    n_words++;
    e.w = w;
    e.a = AW'((n_words - 1) % (2 ** AW));
    e.wc = exp_wc(n_words);
    e.ov = n_words > 2 ** AW;
    sb.push_back(e);
    send_bits(w, 32, ph);
  endtask
  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 20) begin
      cyc(1);
      k++;
    end
    cyc(1);
    chk("drain", 64'(sb.size()), 64'(0));
  endtask
  task automatic flush();
    enable = 1'b0;
    cyc(1);
    enable = 1'b1;
    n_words = 0;
  endtask
  task automatic chk_status(input string nm, input logic ferr);
    chk({nm, "_wc"}, 64'(word_count), 64'(exp_wc(n_words)));
    chk({nm, "_ovf"}, 64'(overflow), 64'(n_words > 2 ** AW));
    chk({nm, "_ferr"}, 64'(frame_err), 64'(ferr));
  endtask
  initial begin
    logic [31:0] burst [3];
    burst[0] = 32'h00000001;
    burst[1] = 32'h80000000;
    burst[2] = 32'hFFFFFFFF;
    #1 reset = 1'b1;
    #2;
    chk("rst_out", 64'(out), 64'(0));
    chk("rst_addr", 64'(addr), 64'(0));
    chk("rst_ready", 64'(ready), 64'(0));
    chk_status("rst", 1'b0);
    cyc(2);
    reset = 1'b0;
    enable = 1'b1;
    cyc(2);
    send_word(32'hDEADBEEF, 4);
    drain();
    chk_status("single", 1'b0);
    flush();
    cyc(1);
    chk_status("flush1", 1'b0);
    for (int i = 0; i < 3; i++) send_word(burst[i], 2);
    drain();
    chk_status("burst", 1'b0);
    flush();
    send_bits($urandom, 10, 0);
    data_clk_pin = 1'b0;
    cyc(60);
    chk_status("timeout", 1'b1);
    send_word(32'h12345678, 0);
    drain();
    chk_status("after_timeout", 1'b1);
    flush();
    cyc(1);
    chk_status("flush_ferr", 1'b0);
    for (int i = 0; i < 5; i++) send_word($urandom, 0);
    drain();
    chk_status("wrap", 1'b0);
    for (int i = 0; i < 4; i++) send_word($urandom, 0);
    drain();
    chk_status("saturate", 1'b0);
    send_bits($urandom, 16, 0);
    enable = 1'b0;
    cyc(1);
    enable = 1'b1;
    n_words = 0;
    cyc(3);
    chk_status("flush_mid", 1'b0);
    send_word(32'hCAFEF00D, 0);
    drain();
    chk_status("cafe", 1'b0);
    for (int r = 0; r < 6; r++) begin
      if ($urandom_range(0, 1) == 1) flush();
      for (int i = 0; i < int'($urandom_range(1, 3)); i++) send_word($urandom, 0);
      drain();
      chk_status("random", 1'b0);
    end
    send_bits($urandom, 16, 0);
    data_clk_pin = 1'b0;
    cyc(3);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("arst_out", 64'(out), 64'(0));
    chk("arst_addr", 64'(addr), 64'(0));
    chk("arst_ready", 64'(ready), 64'(0));
    n_words = 0;
    chk_status("arst", 1'b0);
    cyc(2);
    reset = 1'b0;
    cyc(2);
    send_word($urandom, 0);
    drain();
    chk_status("post_reset", 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/boot_word_loader.md
# boot_word_loader

Serial bootloader front end: samples an externally clocked 1-bit serial stream (data pin plus strobe pin driven by the host), assembles 32-bit instruction words MSB-first, and presents each completed word with an auto-incrementing 12-bit address and a one-cycle `ready` strobe. It sits directly upstream of the instruction ROM write port. The top level gates the strobe with the CPU reset, so programs load only while the processor is held in reset.

## Interface
- `TIMEOUT_CYCLES`, default 1000000: idle `clk` cycles allowed between strobe edges inside a partial word before that word is discarded.
- `ADDR_W`, default 12: word address width.
- `clk`  in  1  system clock; the only clock in the block.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  loader armed; low flushes the partial word and returns the address to 0.
- `data_pin`  in  1  serial data, asynchronous to `clk`.
- `data_clk_pin`  in  1  host strobe, asynchronous to `clk`; data is valid on its rising edge.
- `out`  out  32  last completed word.
- `addr`  out  ADDR_W  address of `out`.
- `ready`  out  1  one-cycle strobe: `out`/`addr` hold a new word.
- `word_count`  out  ADDR_W+1  words completed since reset or since `enable` was low.
- `overflow`  out  1  sticky: address wrapped past 2^ADDR_W−1.
- `frame_err`  out  1  sticky: a partial word timed out.

## Operation
- Reset values: `out`=0, `addr`=0, `ready`=0, `word_count`=0, `overflow`=0, `frame_err`=0, state IDLE, bit counter 0, synchronisers 0.
- Both pins pass through 2-flop synchronisers. A strobe edge is registered synced strobe = 0 followed by synced strobe = 1. Synced data is sampled in the edge cycle.
- Shift register: `sr <= {sr[30:0], data}` on each edge; bit counter counts 0–31.
- States:
  - IDLE: bit counter 0, timer held at 0. An edge shifts bit 31 of the next word and moves to RECV.
  - RECV: timer increments every cycle without an edge and clears on each edge.
    - 32nd edge: `out <= {sr[30:0], data}`, bit counter <= 0, `ready` high the next cycle, back to IDLE.
    - Timer reaching TIMEOUT_CYCLES: partial word discarded, bit counter 0, `frame_err` <= 1, back to IDLE. `out`, `addr`, `word_count` are unchanged.
- Addressing:
  - The first word after reset or after `enable` was low is at `addr`=0.
  - Each later commit loads `addr` = previous `addr` + 1, modulo 2^ADDR_W.
  - Committing when the previous `addr` was 2^ADDR_W−1 wraps to 0 and sets `overflow`.
  - `word_count` increments on every commit and saturates at 2^(ADDR_W+1)−1.
- `enable` low, sampled synchronously:
  - Forces state IDLE and bit counter 0.
  - `addr` resets to "before 0", so the next commit lands at 0.
  - Clears `word_count`, `overflow`, `frame_err` and `ready`.
  - `out` holds its value.
  - Synchronisers and edge detector keep running, so a strobe already high when `enable` rises does not count as an edge.
- Reset mid-word: everything returns to reset values immediately; the partial word is lost.

## Timing
- Pin rising edge to sample cycle: 2–3 `clk` cycles, from synchroniser latency plus phase.
- Last strobe edge to `ready`: `ready` is high exactly 1 cycle after the sample cycle of bit 0 (the 32nd bit). `out`/`addr` are valid in that same cycle and held until the next commit.
- `ready` lasts exactly 1 cycle per word.
- Minimum strobe high time and low time: 2 `clk` periods each. Shorter pulses may be missed; this is not detected.
- The next word's first edge may arrive in the same cycle `ready` is high; it is shifted normally with no loss.
- Timeout fires on the cycle the timer equals TIMEOUT_CYCLES. An edge arriving in that same cycle wins: it is shifted and the timer clears.

## Test plan
- Single word: `enable`=1, shift 0xDEADBEEF MSB-first with 4-cycle strobe phases -> one `ready` pulse, `out`=0xDEADBEEF, `addr`=0, `word_count`=1.
- Burst: 3 back-to-back words 0x00000001, 0x80000000, 0xFFFFFFFF -> three `ready` pulses with `addr` 0, 1, 2 and matching `out`. No word is lost when the next edge coincides with `ready`.
- Timeout: `TIMEOUT_CYCLES`=50, send 10 bits then idle 60 cycles, then a full word 0x12345678 -> `frame_err`=1, no `ready` for the partial, one `ready` with `out`=0x12345678 at `addr`=0.
- Wrap: `ADDR_W`=2, send 5 words -> `addr` sequence 0, 1, 2, 3, 0; `overflow` set on the 5th commit; `word_count`=5.
- Enable flush: send 16 bits, drop `enable` for 1 cycle, raise it with the strobe held high, send 0xCAFEF00D -> `out`=0xCAFEF00D, `addr`=0, `word_count`=1, no spurious edge counted.
- Async reset: assert `reset` mid-word, between `clk` edges -> all outputs 0 immediately; a subsequent full word commits at `addr`=0.
